// File: rtl/alu_pkg.sv
// Shared opcode encodings, comparison result codes and opcode-class decode
// for the registered ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_DIV   = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_NAND  = 4'b0110;
  localparam logic [3:0] ALU_NOR   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_XNOR  = 4'b1001;
  localparam logic [3:0] ALU_CMPEQ = 4'b1010;
  localparam logic [3:0] ALU_CMPGT = 4'b1011;
  localparam logic [3:0] ALU_CMPLT = 4'b1100;
  localparam logic [3:0] ALU_SHR   = 4'b1101;
  localparam logic [3:0] ALU_SHL   = 4'b1110;
  localparam logic [3:0] ALU_NOP   = 4'b1111;

  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;
  localparam logic [1:0] CMP_LT = 2'd3;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ARITH = 3'd1,
    CLS_LOGIC = 3'd2,
    CLS_CMP   = 3'd3,
    CLS_SHIFT = 3'd4
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] fun);
    op_class_e cls;
    case (fun)
      ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV:                   cls = CLS_ARITH;
      ALU_AND, ALU_OR, ALU_NAND, ALU_NOR, ALU_XOR, ALU_XNOR: cls = CLS_LOGIC;
      ALU_CMPEQ, ALU_CMPGT, ALU_CMPLT:                      cls = CLS_CMP;
      ALU_SHR, ALU_SHL:                                     cls = CLS_SHIFT;
      default:                                              cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result mux: zero-extends both operands to out_width and
// selects the function result by opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int data_width = 8,
  parameter int out_width  = 16
) (
  input  logic [data_width-1:0] a_i,
  input  logic [data_width-1:0] b_i,
  input  logic [3:0]            fun_i,
  output logic [out_width-1:0]  result_o
);

  logic [out_width-1:0] a_ext_s;
  logic [out_width-1:0] b_ext_s;

  assign a_ext_s = {{(out_width-data_width){1'b0}}, a_i};
  assign b_ext_s = {{(out_width-data_width){1'b0}}, b_i};

  // Inversions act on the extended operands, so upper result bits read as 1.
  always_comb begin
    result_o = {out_width{1'b0}};
    case (fun_i)
      ALU_ADD:   result_o = a_ext_s + b_ext_s;
      ALU_SUB:   result_o = a_ext_s - b_ext_s;
      ALU_MUL:   result_o = a_ext_s * b_ext_s;
      ALU_DIV: begin
        if (b_ext_s == {out_width{1'b0}}) begin
          result_o = {out_width{1'b0}};
        end else begin
          result_o = a_ext_s / b_ext_s;
        end
      end
      ALU_AND:   result_o = a_ext_s & b_ext_s;
      ALU_OR:    result_o = a_ext_s | b_ext_s;
      ALU_NAND:  result_o = ~(a_ext_s & b_ext_s);
      ALU_NOR:   result_o = ~(a_ext_s | b_ext_s);
      ALU_XOR:   result_o = a_ext_s ^ b_ext_s;
      ALU_XNOR:  result_o = ~(a_ext_s ^ b_ext_s);
      ALU_CMPEQ: begin
        if (a_ext_s == b_ext_s) begin
          result_o = {{(out_width-2){1'b0}}, CMP_EQ};
        end else begin
          result_o = {out_width{1'b0}};
        end
      end
      ALU_CMPGT: begin
        if (a_ext_s > b_ext_s) begin
          result_o = {{(out_width-2){1'b0}}, CMP_GT};
        end else begin
          result_o = {out_width{1'b0}};
        end
      end
      ALU_CMPLT: begin
        if (a_ext_s < b_ext_s) begin
          result_o = {{(out_width-2){1'b0}}, CMP_LT};
        end else begin
          result_o = {out_width{1'b0}};
        end
      end
      ALU_SHR:   result_o = a_ext_s >> 1;
      ALU_SHL:   result_o = a_ext_s << 1;
      default:   result_o = {out_width{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle result/valid registers around alu_core and
// combinational opcode-class flags.
module alu
  import alu_pkg::*;
#(
  parameter int data_width = 8,
  parameter int out_width  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  En,
  output logic [out_width-1:0]  ALU_OUT,
  output logic                  ALU_Valid,
  output logic                  Arith_Flag,
  output logic                  Logic_Flag,
  output logic                  CMP_Flag,
  output logic                  Shift_Flag
);

  logic [out_width-1:0] result_s;
  logic [out_width-1:0] alu_out_d;
  logic [out_width-1:0] alu_out_q;
  logic                 valid_d;
  logic                 valid_q;
  op_class_e            cls_s;

  alu_core #(
    .data_width (data_width),
    .out_width  (out_width)
  ) u_core (
    .a_i      (A),
    .b_i      (B),
    .fun_i    (ALU_FUN),
    .result_o (result_s)
  );

  // Capture on En; otherwise hold the result and drop valid.
  always_comb begin
    alu_out_d = alu_out_q;
    valid_d   = 1'b0;
    if (En) begin
      alu_out_d = result_s;
      valid_d   = 1'b1;
    end else begin
      alu_out_d = alu_out_q;
      valid_d   = 1'b0;
    end
  end

  // Synchronous active-low reset overrides En and discards any pending result.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      alu_out_q <= {out_width{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      valid_q   <= valid_d;
    end
  end

  assign ALU_OUT   = alu_out_q;
  assign ALU_Valid = valid_q;

  assign cls_s      = op_class(ALU_FUN);
  assign Arith_Flag = (cls_s == CLS_ARITH);
  assign Logic_Flag = (cls_s == CLS_LOGIC);
  assign CMP_Flag   = (cls_s == CLS_CMP);
  assign Shift_Flag = (cls_s == CLS_SHIFT);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: behavioural reference model, per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_alu;

  localparam int DW = 8;
  localparam int OW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [3:0]    ALU_FUN;
  logic          En;
  logic [OW-1:0] ALU_OUT;
  logic          ALU_Valid;
  logic          Arith_Flag;
  logic          Logic_Flag;
  logic          CMP_Flag;
  logic          Shift_Flag;

  int errors = 0;
  int checks = 0;

  alu #(.data_width(DW), .out_width(OW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .En         (En),
    .ALU_OUT    (ALU_OUT),
    .ALU_Valid  (ALU_Valid),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag)
  );

  always #5 CLK = ~CLK;

  // Reference function, computed on wide unsigned integers then truncated.
  function automatic logic [OW-1:0] model_f(input int unsigned a, input int unsigned b,
                                            input int unsigned f);
    longint unsigned r;
    case (f)
      0:  r = a + b;
      1:  r = longint'(a) - longint'(b);
      2:  r = a * b;
      3:  r = (b == 0) ? 0 : a / b;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a & b);
      7:  r = ~(a | b);
      8:  r = a ^ b;
      9:  r = ~(a ^ b);
      10: r = (a == b) ? 1 : 0;
      11: r = (a > b) ? 2 : 0;
      12: r = (a < b) ? 3 : 0;
      13: r = a / 2;
      14: r = a * 2;
      default: r = 0;
    endcase
    return r[OW-1:0];
  endfunction

  function automatic logic [3:0] model_flags(input int unsigned f);
    // {arith, logic, cmp, shift}
    if (f <= 3)       return 4'b1000;
    else if (f <= 9)  return 4'b0100;
    else if (f <= 12) return 4'b0010;
    else if (f <= 14) return 4'b0001;
    else              return 4'b0000;
  endfunction

  logic [OW-1:0] m_out;
  logic          m_valid;
  logic          m_live = 1'b0;

  // Model state: what the registered outputs must hold after each edge.
  always @(posedge CLK) begin
    if (RST === 1'b0) begin
      m_out   <= '0;
      m_valid <= 1'b0;
      m_live  <= 1'b1;
    end else if (En === 1'b1) begin
      m_out   <= model_f(A, B, ALU_FUN);
      m_valid <= 1'b1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge CLK) begin
    logic [3:0] fl;
    fl = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
    checks++;
    if (fl !== model_flags(ALU_FUN)) begin
      errors++;
      $display("FAIL flags fun=%0d: got %b want %b", ALU_FUN, fl, model_flags(ALU_FUN));
    end
    if (m_live) begin
      checks++;
      if (ALU_Valid !== m_valid || ALU_OUT !== m_out) begin
        errors++;
        $display("FAIL model t=%0t: ALU_OUT=%h valid=%b, want %h/%b",
                 $time, ALU_OUT, ALU_Valid, m_out, m_valid);
      end
    end
  end

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] f, input logic e, input logic r);
    @(negedge CLK);
    #1;
    A = a; B = b; ALU_FUN = f; En = e; RST = r;
  endtask

  task automatic pin(input string name, input logic [OW-1:0] want_out, input logic want_v);
    @(posedge CLK);
    #2;
    checks++;
    if (ALU_OUT !== want_out || ALU_Valid !== want_v) begin
      errors++;
      $display("FAIL %s: ALU_OUT=%h valid=%b, want %h/%b", name, ALU_OUT, ALU_Valid,
               want_out, want_v);
    end
  endtask

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    f;
    logic [OW-1:0] want;
  } vec_t;

  vec_t vecs[$];

  initial begin
    RST = 1'b0; En = 1'b1; A = 8'd15; B = 8'd3; ALU_FUN = 4'd0;

    // Reset held for two edges with En high.
    @(posedge CLK);
    pin("reset", 16'h0000, 1'b0);

    vecs = '{
      '{8'd15, 8'd3, 4'd0, 16'd18},    '{8'd15, 8'd3, 4'd1, 16'd12},
      '{8'd15, 8'd3, 4'd2, 16'd45},    '{8'd15, 8'd3, 4'd3, 16'd5},
      '{8'd15, 8'd3, 4'd4, 16'd3},     '{8'd15, 8'd3, 4'd5, 16'd15},
      '{8'd15, 8'd3, 4'd6, 16'hFFFC},  '{8'd15, 8'd3, 4'd7, 16'hFFF0},
      '{8'd15, 8'd3, 4'd8, 16'd12},    '{8'd15, 8'd3, 4'd9, 16'hFFF3},
      '{8'd15, 8'd3, 4'd10, 16'd0},    '{8'd15, 8'd3, 4'd11, 16'd2},
      '{8'd15, 8'd3, 4'd12, 16'd0},    '{8'd7, 8'd7, 4'd10, 16'd1},
      '{8'd2, 8'd9, 4'd12, 16'd3},     '{8'd4, 8'd0, 4'd13, 16'd2},
      '{8'd4, 8'd0, 4'd14, 16'd8},     '{8'd9, 8'd4, 4'd15, 16'd0},
      '{8'd3, 8'd5, 4'd1, 16'hFFFE},   '{8'd255, 8'd255, 4'd2, 16'hFE01},
      '{8'd255, 8'd0, 4'd14, 16'h01FE}, '{8'd200, 8'd0, 4'd3, 16'd0}
    };
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].f, 1'b1, 1'b1);
      pin($sformatf("vec%0d_fun%0d", i, vecs[i].f), vecs[i].want, 1'b1);
    end

    // Enable drop: result holds, valid falls.
    drive(8'd15, 8'd3, 4'd0, 1'b1, 1'b1);
    pin("en_load", 16'd18, 1'b1);
    drive(8'd15, 8'd3, 4'd2, 1'b0, 1'b1);
    pin("en_hold1", 16'd18, 1'b0);
    drive(8'd1, 8'd1, 4'd5, 1'b0, 1'b1);
    pin("en_hold2", 16'd18, 1'b0);

    // Mid-stream reset discards the captured result.
    drive(8'd15, 8'd3, 4'd2, 1'b1, 1'b1);
    pin("pre_reset", 16'd45, 1'b1);
    drive(8'd15, 8'd3, 4'd0, 1'b1, 1'b0);
    pin("mid_reset", 16'd0, 1'b0);

    // Back-to-back opcodes; the compare process tracks every cycle.
    for (int i = 0; i < 32; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i % 16), 1'b1, 1'b1);
    end

    // Randomized traffic with biased corners, En gaps and occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) rb = ra;
      drive(ra, rb, 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 85),
            !($urandom_range(0, 99) < 3));
    end

    drive(8'd0, 8'd0, 4'd15, 1'b0, 1'b1);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
